// File: rtl/avl_arb_master_if.sv
// Avalon-MM host-port bundle shared by the arbitrating bridge and the fabric.
// The master modport is the bridge side; the slave modport is the fabric side.
interface avl_arb_master_if #(
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic [31:0]       address;
  logic              read;
  logic              write;
  logic [BE_W-1:0]   byteenable;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              waitrequest;

  modport master (
    output address, read, write, byteenable, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, byteenable, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/avl_arb_master.sv
// Avalon-MM host bridge: N_CH request channels share one Avalon host port
// through round-robin arbitration. Each channel owns a one-entry pending slot.
// A request can go out on the same edge it is accepted, and the next command
// can be issued on the same edge that the current one completes.
module avl_arb_master #(
  parameter int N_CH     = 3,
  parameter int DATA_W   = 32,
  parameter int WADDR_W  = 30,
  parameter int ADDR_LSB = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_CH-1:0]            ch_start_i,
  input  logic [N_CH-1:0]            ch_write_i,
  input  logic [N_CH*WADDR_W-1:0]    ch_addr_i,
  input  logic [N_CH*DATA_W-1:0]     ch_wdata_i,
  input  logic [N_CH*(DATA_W/8)-1:0] ch_be_i,
  output logic [N_CH-1:0]            ch_busy_o,
  output logic [N_CH-1:0]            ch_ready_o,
  output logic [DATA_W-1:0]          ch_rdata_o,
  avl_arb_master_if.master           avl
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  // Bus FSM and arbitration state
  state_t             state_q;
  logic [IDX_W-1:0]   grant_q;
  logic [IDX_W-1:0]   rr_q;

  // Registered Avalon command
  logic [31:0]        avl_address_q;
  logic               avl_read_q;
  logic               avl_write_q;
  logic [BE_W-1:0]    avl_be_q;
  logic [DATA_W-1:0]  avl_wdata_q;

  // Per-channel pending slots
  logic [N_CH-1:0]    pend_q;
  logic [N_CH-1:0]    slot_write_q;
  logic [WADDR_W-1:0] slot_addr_q  [N_CH];
  logic [DATA_W-1:0]  slot_wdata_q [N_CH];
  logic [BE_W-1:0]    slot_be_q    [N_CH];

  // Unpacked channel inputs and effective request fields
  logic [WADDR_W-1:0] in_addr   [N_CH];
  logic [DATA_W-1:0]  in_wdata  [N_CH];
  logic [BE_W-1:0]    in_be     [N_CH];
  logic [N_CH-1:0]    req_write;
  logic [WADDR_W-1:0] req_addr  [N_CH];
  logic [DATA_W-1:0]  req_wdata [N_CH];
  logic [BE_W-1:0]    req_be    [N_CH];

  logic [N_CH-1:0]    accept;
  logic [N_CH-1:0]    req;
  logic               busy_st;
  logic               done;
  logic               free;
  logic               issue;
  logic [IDX_W-1:0]   pick;
  logic               pick_found;
  logic [31:0]        pick_address;

  assign busy_st = (state_q == ST_BUSY);
  assign done    = busy_st & ~avl.waitrequest;
  assign free    = ~busy_st | done;
  assign issue   = free & (|req);

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      assign in_addr[gi]  = ch_addr_i[gi*WADDR_W +: WADDR_W];
      assign in_wdata[gi] = ch_wdata_i[gi*DATA_W +: DATA_W];
      assign in_be[gi]    = ch_be_i[gi*BE_W +: BE_W];

      // A channel is busy while it holds a pending request or owns the bus.
      assign ch_busy_o[gi]  = pend_q[gi] | (busy_st & (grant_q == IDX_W'(gi)));
      assign ch_ready_o[gi] = done & (grant_q == IDX_W'(gi));

      // The owner may restart in its completion cycle; otherwise busy drops it.
      assign accept[gi] = ch_start_i[gi] &
                          (~ch_busy_o[gi] | (done & (grant_q == IDX_W'(gi))));
      assign req[gi]    = pend_q[gi] | accept[gi];

      // Pending slot wins; a fresh start is forwarded straight from the inputs.
      assign req_write[gi] = pend_q[gi] ? slot_write_q[gi] : ch_write_i[gi];
      assign req_addr[gi]  = pend_q[gi] ? slot_addr_q[gi]  : in_addr[gi];
      assign req_wdata[gi] = pend_q[gi] ? slot_wdata_q[gi] : in_wdata[gi];
      assign req_be[gi]    = pend_q[gi] ? slot_be_q[gi]    : in_be[gi];
    end
  endgenerate

  // Round-robin pick: first requester strictly after rr_q, then wrap to 0..rr_q.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (!pick_found && req[c] && (c > int'(rr_q))) begin
        pick_found = 1'b1;
        pick       = IDX_W'(c);
      end
    end
    for (int c = 0; c < N_CH; c++) begin
      if (!pick_found && req[c] && (c <= int'(rr_q))) begin
        pick_found = 1'b1;
        pick       = IDX_W'(c);
      end
    end
  end

  // Byte address of the picked request: word address shifted up by ADDR_LSB.
  always_comb begin
    pick_address = '0;
    pick_address[ADDR_LSB +: WADDR_W] = req_addr[pick];
  end

  // Bus FSM, arbitration pointer, Avalon command registers and slot valid bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      rr_q          <= IDX_W'(N_CH - 1);
      avl_address_q <= '0;
      avl_read_q    <= 1'b0;
      avl_write_q   <= 1'b0;
      avl_be_q      <= '0;
      avl_wdata_q   <= '0;
      pend_q        <= '0;
    end else begin
      if (issue) begin
        state_q       <= ST_BUSY;
        grant_q       <= pick;
        rr_q          <= pick;
        avl_address_q <= pick_address;
        avl_read_q    <= ~req_write[pick];
        avl_write_q   <= req_write[pick];
        avl_be_q      <= req_be[pick];
        avl_wdata_q   <= req_wdata[pick];
      end else if (done) begin
        state_q     <= ST_IDLE;
        avl_read_q  <= 1'b0;
        avl_write_q <= 1'b0;
      end
      for (int c = 0; c < N_CH; c++) begin
        if (issue && (pick == IDX_W'(c))) begin
          pend_q[c] <= 1'b0;
        end else if (accept[c]) begin
          pend_q[c] <= 1'b1;
        end
      end
    end
  end

  // Slot payload capture; only meaningful while the matching pend_q bit is set.
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (accept[c]) begin
        slot_write_q[c] <= ch_write_i[c];
        slot_addr_q[c]  <= in_addr[c];
        slot_wdata_q[c] <= in_wdata[c];
        slot_be_q[c]    <= in_be[c];
      end
    end
  end

  assign avl.address    = avl_address_q;
  assign avl.read       = avl_read_q;
  assign avl.write      = avl_write_q;
  assign avl.byteenable = avl_be_q;
  assign avl.writedata  = avl_wdata_q;
  assign ch_rdata_o     = avl.readdata;

endmodule

// File: tb/tb_avl_arb_master.sv
// Directed bench for avl_arb_master: reset, single read with wait states,
// three-way arbitration, round-robin fairness, write hold, reset mid-transfer.
module tb_avl_arb_master;
  localparam int N_CH     = 3;
  localparam int DATA_W   = 32;
  localparam int WADDR_W  = 30;
  localparam int ADDR_LSB = 2;
  localparam int BE_W     = DATA_W / 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [N_CH-1:0]         ch_start = '0;
  logic [N_CH-1:0]         ch_write = '0;
  logic [N_CH*WADDR_W-1:0] ch_addr  = '0;
  logic [N_CH*DATA_W-1:0]  ch_wdata = '0;
  logic [N_CH*BE_W-1:0]    ch_be    = '0;
  logic [N_CH-1:0]         ch_busy;
  logic [N_CH-1:0]         ch_ready;
  logic [DATA_W-1:0]       ch_rdata;

  int total = 0;
  int bad   = 0;

  avl_arb_master_if #(.DATA_W(DATA_W)) bus();

  avl_arb_master #(
    .N_CH(N_CH), .DATA_W(DATA_W), .WADDR_W(WADDR_W), .ADDR_LSB(ADDR_LSB)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ch_start_i(ch_start), .ch_write_i(ch_write), .ch_addr_i(ch_addr),
    .ch_wdata_i(ch_wdata), .ch_be_i(ch_be),
    .ch_busy_o(ch_busy), .ch_ready_o(ch_ready), .ch_rdata_o(ch_rdata),
    .avl(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int ch, input logic wr, input logic [WADDR_W-1:0] a,
                         input logic [DATA_W-1:0] wd, input logic [BE_W-1:0] be);
    ch_start[ch]                 = 1'b1;
    ch_write[ch]                 = wr;
    ch_addr[ch*WADDR_W +: WADDR_W] = a;
    ch_wdata[ch*DATA_W +: DATA_W]  = wd;
    ch_be[ch*BE_W +: BE_W]         = be;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    ch_start = '0;
    step();
    rst_n    = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.waitrequest = 1'b1; bus.readdata = '0; ch_start = '0;
    step(); step();
    total++; if (bus.read !== 1'b0) begin bad++; $display("FAIL reset_read got=%b exp=0", bus.read); end
    total++; if (bus.write !== 1'b0) begin bad++; $display("FAIL reset_write got=%b exp=0", bus.write); end
    total++; if (bus.address !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bus.address); end
    total++; if (bus.byteenable !== 4'h0) begin bad++; $display("FAIL reset_be got=%h exp=0", bus.byteenable); end
    total++; if (bus.writedata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", bus.writedata); end
    total++; if (ch_busy !== 3'b000) begin bad++; $display("FAIL reset_busy got=%b exp=000", ch_busy); end
    total++; if (ch_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", ch_ready); end
    $display("test_reset checked");
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    bus.waitrequest = 1'b1; bus.readdata = 32'hDEADBEEF;
    set_req(1, 1'b0, 30'h10, 32'h0, 4'hF);
    #1;
    total++; if (ch_busy !== 3'b000) begin bad++; $display("FAIL single_busy_pre got=%b exp=000", ch_busy); end
    step();
    ch_start = '0;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (bus.read !== 1'b1) begin bad++; $display("FAIL single_read_hold[%0d] got=%b exp=1", k, bus.read); end
      total++; if (bus.address !== 32'h40) begin bad++; $display("FAIL single_addr[%0d] got=%h exp=00000040", k, bus.address); end
      total++; if (bus.byteenable !== 4'hF) begin bad++; $display("FAIL single_be[%0d] got=%h exp=f", k, bus.byteenable); end
      total++; if (ch_ready !== 3'b000) begin bad++; $display("FAIL single_ready_wait[%0d] got=%b exp=000", k, ch_ready); end
      total++; if (ch_busy !== 3'b010) begin bad++; $display("FAIL single_busy[%0d] got=%b exp=010", k, ch_busy); end
      step();
    end
    bus.waitrequest = 1'b0;
    #1;
    total++; if (bus.read !== 1'b1) begin bad++; $display("FAIL single_read_last got=%b exp=1", bus.read); end
    total++; if (ch_ready !== 3'b010) begin bad++; $display("FAIL single_ready got=%b exp=010", ch_ready); end
    total++; if (ch_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rdata got=%h exp=deadbeef", ch_rdata); end
    step();
    total++; if (bus.read !== 1'b0) begin bad++; $display("FAIL single_read_end got=%b exp=0", bus.read); end
    total++; if (ch_busy !== 3'b000) begin bad++; $display("FAIL single_busy_end got=%b exp=000", ch_busy); end
    total++; if (ch_ready !== 3'b000) begin bad++; $display("FAIL single_ready_end got=%b exp=000", ch_ready); end
    $display("test_single_read checked");
  endtask

  task automatic test_three_channels();
    logic [2:0]  exp_ready [3] = '{3'b001, 3'b010, 3'b100};
    logic [2:0]  exp_busy  [3] = '{3'b111, 3'b110, 3'b100};
    logic [31:0] exp_addr  [3] = '{32'h400, 32'h800, 32'hC00};
    do_reset();
    bus.waitrequest = 1'b0;
    set_req(0, 1'b0, 30'h100, 32'h0, 4'hF);
    set_req(1, 1'b0, 30'h200, 32'h0, 4'hF);
    set_req(2, 1'b0, 30'h300, 32'h0, 4'hF);
    step();
    ch_start = '0;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (ch_ready !== exp_ready[k]) begin bad++; $display("FAIL three_ready[%0d] got=%b exp=%b", k, ch_ready, exp_ready[k]); end
      total++; if (bus.address !== exp_addr[k]) begin bad++; $display("FAIL three_addr[%0d] got=%h exp=%h", k, bus.address, exp_addr[k]); end
      total++; if (bus.read !== 1'b1) begin bad++; $display("FAIL three_read[%0d] got=%b exp=1", k, bus.read); end
      total++; if (ch_busy !== exp_busy[k]) begin bad++; $display("FAIL three_busy[%0d] got=%b exp=%b", k, ch_busy, exp_busy[k]); end
      step();
    end
    total++; if (bus.read !== 1'b0) begin bad++; $display("FAIL three_read_end got=%b exp=0", bus.read); end
    total++; if (ch_busy !== 3'b000) begin bad++; $display("FAIL three_busy_end got=%b exp=000", ch_busy); end
    $display("test_three_channels checked");
  endtask

  task automatic test_fairness();
    int exp_ch [4] = '{0, 2, 0, 2};
    logic [2:0] exp_r;
    do_reset();
    bus.waitrequest = 1'b0;
    set_req(0, 1'b0, 30'h11, 32'h0, 4'hF);
    set_req(2, 1'b0, 30'h22, 32'h0, 4'hF);
    step();
    for (int k = 0; k < 4; k++) begin
      ch_start = '0;
      if (k < 3) ch_start[exp_ch[k]] = 1'b1;
      #1;
      exp_r = 3'b000;
      exp_r[exp_ch[k]] = 1'b1;
      total++; if (ch_ready !== exp_r) begin bad++; $display("FAIL fair_grant[%0d] got=%b exp=%b", k, ch_ready, exp_r); end
      step();
    end
    total++; if (ch_ready !== 3'b001) begin bad++; $display("FAIL fair_drain got=%b exp=001", ch_ready); end
    total++; if (bus.read !== 1'b1) begin bad++; $display("FAIL fair_read_cont got=%b exp=1", bus.read); end
    step();
    total++; if (bus.read !== 1'b0) begin bad++; $display("FAIL fair_read_end got=%b exp=0", bus.read); end
    total++; if (ch_busy !== 3'b000) begin bad++; $display("FAIL fair_busy_end got=%b exp=000", ch_busy); end
    $display("test_fairness checked");
  endtask

  task automatic test_write();
    do_reset();
    bus.waitrequest = 1'b1;
    set_req(2, 1'b1, 30'h20, 32'h12345678, 4'b0011);
    step();
    ch_start = '0;
    #1;
    total++; if (bus.write !== 1'b1) begin bad++; $display("FAIL wr_write got=%b exp=1", bus.write); end
    total++; if (bus.read !== 1'b0) begin bad++; $display("FAIL wr_read got=%b exp=0", bus.read); end
    total++; if (ch_busy !== 3'b100) begin bad++; $display("FAIL wr_busy got=%b exp=100", ch_busy); end
    for (int k = 0; k < 3; k++) begin
      total++; if (bus.writedata !== 32'h12345678) begin bad++; $display("FAIL wr_wdata[%0d] got=%h exp=12345678", k, bus.writedata); end
      total++; if (bus.byteenable !== 4'h3) begin bad++; $display("FAIL wr_be[%0d] got=%h exp=3", k, bus.byteenable); end
      total++; if (bus.address !== 32'h80) begin bad++; $display("FAIL wr_addr[%0d] got=%h exp=00000080", k, bus.address); end
      total++; if (bus.write !== 1'b1) begin bad++; $display("FAIL wr_hold[%0d] got=%b exp=1", k, bus.write); end
      if (k == 0) set_req(2, 1'b1, 30'h30, 32'hAAAA5555, 4'hC);
      step();
      ch_start = '0;
      #1;
    end
    bus.waitrequest = 1'b0;
    #1;
    total++; if (ch_ready !== 3'b100) begin bad++; $display("FAIL wr_ready got=%b exp=100", ch_ready); end
    step();
    total++; if (bus.write !== 1'b0) begin bad++; $display("FAIL wr_write_end got=%b exp=0", bus.write); end
    total++; if (ch_busy !== 3'b000) begin bad++; $display("FAIL wr_drop_busy got=%b exp=000", ch_busy); end
    $display("test_write checked");
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.waitrequest = 1'b1;
    set_req(0, 1'b0, 30'h5, 32'h0, 4'hF);
    set_req(1, 1'b0, 30'h6, 32'h0, 4'hF);
    step();
    ch_start = '0;
    #1;
    total++; if (bus.read !== 1'b1) begin bad++; $display("FAIL mid_read_pre got=%b exp=1", bus.read); end
    total++; if (ch_busy !== 3'b011) begin bad++; $display("FAIL mid_busy_pre got=%b exp=011", ch_busy); end
    rst_n = 1'b0;
    step();
    total++; if (bus.read !== 1'b0) begin bad++; $display("FAIL mid_read got=%b exp=0", bus.read); end
    total++; if (ch_busy !== 3'b000) begin bad++; $display("FAIL mid_busy got=%b exp=000", ch_busy); end
    total++; if (bus.address !== 32'h0) begin bad++; $display("FAIL mid_addr got=%h exp=0", bus.address); end
    rst_n = 1'b1;
    bus.waitrequest = 1'b0;
    step();
    total++; if (bus.read !== 1'b0) begin bad++; $display("FAIL mid_read_after got=%b exp=0", bus.read); end
    total++; if (ch_busy !== 3'b000) begin bad++; $display("FAIL mid_busy_after got=%b exp=000", ch_busy); end
    $display("test_reset_mid checked");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_three_channels();
    test_fairness();
    test_write();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
